hamming_secded_pipe: RTL and testbench

Pipelined, parametrised SECDED Hamming codec with a runtime encode/decode mode and a valid/ready handshake on both sides. Decode mode corrects single-bit errors, flags double-bit errors and reports the error position. Saturating error-event counters are included for the memory/link ECC wrappers in gray_area_package users. It is the streaming successor to the combinational hamming parity block and uses the same codeword layout.

---
 rtl/hamming_secded_pipe.sv | 172 +++++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe
//   Two-stage streaming SECDED Hamming codec with a per-beat encode/decode
//   mode and valid/ready handshakes on both sides.
//   Codeword layout: bit 0 = overall parity, bit 2**i = parity i, data bits
//   fill the remaining positions 3,5,6,7,9,... LSB first. Positions above
//   N = DATA_WIDTH+ADDR_WIDTH are always zero.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   in_valid_i/in_ready_o        input handshake
//   mode_i                       0 = encode, 1 = decode (sampled with the beat)
//   data_i                       encode: payload in low bits; decode: codeword
//   out_valid_o/out_ready_i      output handshake
//   coded_o, data_o              codeword (corrected) and payload
//   single_err_o, double_err_o   decode flags
//   err_pos_o                    corrected bit position, else 0
//   corr_cnt_o, uncorr_cnt_o     saturating event counters
//   cnt_clr_i                    synchronous counter clear (wins over increment)
module hamming_secded_pipe #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  CNT_WIDTH   = 16,
  // Fixed-point iteration of p = clog2(DATA_WIDTH+p+1); three steps converge.
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH +
                               $clog2(DATA_WIDTH + 1) + 1) + 1),
  localparam int CODED_WIDTH = 2 ** ADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   mode_i,
  input  logic [CODED_WIDTH-1:0] data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CODED_WIDTH-1:0] coded_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   single_err_o,
  output logic                   double_err_o,
  output logic [ADDR_WIDTH:0]    err_pos_o,
  output logic [CNT_WIDTH-1:0]   corr_cnt_o,
  output logic [CNT_WIDTH-1:0]   uncorr_cnt_o,
  input  logic                   cnt_clr_i
);

  localparam int N = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] N_A = ADDR_WIDTH'(N);

  typedef struct packed {
    logic                   mode;
    logic [CODED_WIDTH-1:0] word;  // encode: data scattered, parity slots 0
    logic [ADDR_WIDTH-1:0]  syn;   // encode: parity bits; decode: syndrome
    logic                   par;   // XOR of word[0..N]
  } s1_t;

  typedef struct packed {
    logic [CODED_WIDTH-1:0] coded;
    logic [DATA_WIDTH-1:0]  data;
    logic                   single_err;
    logic                   double_err;
    logic [ADDR_WIDTH:0]    pos;
  } s2_t;

  function automatic logic [CODED_WIDTH-1:0] scatter(input logic [DATA_WIDTH-1:0] d);
    int k;
    scatter = '0;
    k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        scatter[p] = d[k];
        k++;
      end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODED_WIDTH-1:0] w);
    int k;
    extract = '0;
    k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        extract[k] = w[p];
        k++;
      end
  endfunction

  logic [2:1] vld_pipe;
  logic       s1_adv, s2_adv, out_hs;
  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;

  assign s2_adv     = !vld_pipe[2] | out_ready_i;
  assign s1_adv     = !vld_pipe[1] | s2_adv;
  assign in_ready_o = s1_adv;
  assign out_hs     = vld_pipe[2] & out_ready_i;

  // Stage 1: one syndrome tree serves both modes. In encode the parity slots
  // of the scattered word are zero, so the syndrome equals the parity bits.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = mode_i;
    if (mode_i) begin
      for (int p = 0; p <= N; p++) s1_d.word[p] = data_i[p];
    end else begin
      s1_d.word = scatter(data_i[DATA_WIDTH-1:0]);
    end
    for (int p = 1; p <= N; p++)
      for (int i = 0; i < ADDR_WIDTH; i++)
        if (p[i]) s1_d.syn[i] = s1_d.syn[i] ^ s1_d.word[p];
    s1_d.par = ^s1_d.word;
  end

  // Stage 2: parity insertion (encode) or classification/correction (decode).
  always_comb begin
    s2_d       = '0;
    s2_d.coded = s1_q.word;
    if (!s1_q.mode) begin
      for (int i = 0; i < ADDR_WIDTH; i++) s2_d.coded[1 << i] = s1_q.syn[i];
      // word[0] is 0 here, so par is the data XOR; add the parity bits.
      s2_d.coded[0] = s1_q.par ^ (^s1_q.syn);
    end else if (s1_q.par) begin
      if (s1_q.syn == '0) begin
        s2_d.coded[0]   = ~s1_q.word[0];
        s2_d.single_err = 1'b1;
      end else if (s1_q.syn <= N_A) begin
        s2_d.coded[s1_q.syn] = ~s1_q.word[s1_q.syn];
        s2_d.single_err      = 1'b1;
        s2_d.pos             = {1'b0, s1_q.syn};
      end else begin
        s2_d.double_err = 1'b1;  // odd weight but syndrome outside codeword
      end
    end else if (s1_q.syn != '0) begin
      s2_d.double_err = 1'b1;
    end
    s2_d.data = extract(s2_d.coded);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid_i;
        if (in_valid_i) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (out_hs) begin
      if (s2_q.single_err && corr_cnt_o != '1)   corr_cnt_o   <= corr_cnt_o + 1'b1;
      if (s2_q.double_err && uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
    end
  end

  assign out_valid_o  = vld_pipe[2];
  assign coded_o      = s2_q.coded;
  assign data_o       = s2_q.data;
  assign single_err_o = s2_q.single_err;
  assign double_err_o = s2_q.double_err;
  assign err_pos_o    = s2_q.pos;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe
//   Self-checking bench: directed vector table, counter saturation/clear,
//   backpressure, randomized traffic and mid-stream reset. A negedge monitor
//   compares every output handshake against a queue of expectations from a
//   behavioural SECDED model, and tracks the saturating counters.
module tb_hamming_secded_pipe;
  localparam int DW = 32, CW = 2, AW = 6, NW = 64, N = DW + AW;

  logic          clk_i = 0, rst_i = 1, in_valid_i = 0, mode_i = 0;
  logic          out_ready_i = 1, cnt_clr_i = 0;
  logic [NW-1:0] data_i = '0;
  logic          in_ready_o, out_valid_o, single_err_o, double_err_o;
  logic [NW-1:0] coded_o;
  logic [DW-1:0] data_o;
  logic [AW:0]   err_pos_o;
  logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;

  hamming_secded_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mode_i(mode_i), .data_i(data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .coded_o(coded_o), .data_o(data_o), .single_err_o(single_err_o),
    .double_err_o(double_err_o), .err_pos_o(err_pos_o), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o), .cnt_clr_i(cnt_clr_i));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NW-1:0] coded;
    logic [DW-1:0] data;
    logic          se;
    logic          de;
    logic [AW:0]   pos;
  } res_t;

  typedef struct {
    logic          m;
    logic [NW-1:0] din;
    res_t          r;
  } vec_t;

  int   total = 0, passed = 0;
  res_t expq[$];
  int   mcc = 0, muc = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pull_data(input logic [NW-1:0] cw);
    int k = 0;
    pull_data = '0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin pull_data[k] = cw[p]; k++; end
  endfunction

  // Behavioural model: syndrome is the XOR of the indices of all set bits.
  function automatic res_t ref_model(input logic m, input logic [NW-1:0] d);
    res_t r; logic [NW-1:0] cw; int k, syn; logic q;
    r = '0; cw = '0;
    if (!m) begin
      k = 0;
      for (int p = 1; p <= N; p++)
        if ((p & (p - 1)) != 0) begin cw[p] = d[k]; k++; end
      for (int i = 0; i < AW; i++) begin
        q = 0;
        for (int p = 1; p <= N; p++) if (((p >> i) & 1) == 1) q ^= cw[p];
        cw[1 << i] = q;
      end
      cw[0] = ^cw;
      r.coded = cw;
      r.data  = d[DW-1:0];
    end else begin
      for (int p = 0; p <= N; p++) cw[p] = d[p];
      syn = 0;
      for (int p = 1; p <= N; p++) if (cw[p]) syn ^= p;
      q = ^cw;
      if (q && syn == 0) begin cw[0] = ~cw[0]; r.se = 1; end
      else if (q && syn <= N) begin cw[syn] = ~cw[syn]; r.se = 1; r.pos = 7'(syn); end
      else if (syn != 0) r.de = 1;
      r.coded = cw;
      r.data  = pull_data(cw);
    end
    return r;
  endfunction

  task automatic gen_beat(output logic m, output logic [NW-1:0] d);
    res_t enc; int a, b, nf;
    m = 1'($urandom_range(0, 1));
    if (!m) d = {$urandom, $urandom};  // upper junk must be ignored
    else begin
      enc = ref_model(0, {32'h0, $urandom});
      d  = enc.coded;
      nf = $urandom_range(0, 2);
      a  = $urandom_range(0, N);
      b  = (a + $urandom_range(1, N)) % (N + 1);
      if (nf >= 1) d[a] = ~d[a];
      if (nf == 2) d[b] = ~d[b];
    end
  endtask

  // Monitor: inputs change at posedge+1, so negedge sees what the next edge samples.
  always @(negedge clk_i) begin
    res_t e; logic hs;
    if (rst_i) begin
      expq.delete(); mcc = 0; muc = 0;
    end else begin
      check("corr_cnt", 64'(corr_cnt_o), 64'(mcc));
      check("uncorr_cnt", 64'(uncorr_cnt_o), 64'(muc));
      hs = out_valid_o && out_ready_i;
      e  = '0;
      if (hs) begin
        if (expq.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = expq.pop_front();
          check("mon_coded", coded_o, e.coded);
          check("mon_data", 64'(data_o), 64'(e.data));
          check("mon_single", 64'(single_err_o), 64'(e.se));
          check("mon_double", 64'(double_err_o), 64'(e.de));
          check("mon_pos", 64'(err_pos_o), 64'(e.pos));
        end
      end
      if (cnt_clr_i) begin mcc = 0; muc = 0; end
      else if (hs) begin
        if (e.se && mcc < CMAX) mcc++;
        if (e.de && muc < CMAX) muc++;
      end
      if (in_valid_i && in_ready_o) expq.push_back(ref_model(mode_i, data_i));
    end
  end

  task automatic send(input logic m, input logic [NW-1:0] d);
    int n = 0;
    in_valid_i = 1; mode_i = m; data_i = d;
    @(negedge clk_i);
    while (!in_ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge clk_i); #1;
    in_valid_i = 0;
  endtask

  vec_t          vt[7];
  logic          bm[4];
  logic [NW-1:0] bd[4];

  initial begin
    logic took; int acc;
    vt[0] = '{0, 64'h1,           '{64'hF, 32'h1, 0, 0, 7'd0}};
    vt[1] = '{0, 64'h0,           '{64'h0, 32'h0, 0, 0, 7'd0}};
    vt[2] = '{1, 64'hF,           '{64'hF, 32'h1, 0, 0, 7'd0}};
    vt[3] = '{1, 64'h2F,          '{64'hF, 32'h1, 1, 0, 7'd5}};
    vt[4] = '{1, 64'hE,           '{64'hF, 32'h1, 1, 0, 7'd0}};
    vt[5] = '{1, 64'h6F,          '{64'h6F, 32'h7, 0, 1, 7'd0}};
    vt[6] = '{1, 64'h1_0000_0102, '{64'h1_0000_0102, 32'h0, 0, 1, 7'd0}};

    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid_o), 0);
    check("rst_in_ready", 64'(in_ready_o), 1);
    check("rst_coded", coded_o, 0);
    check("rst_flags", 64'({single_err_o, double_err_o, err_pos_o}), 0);
    @(posedge clk_i); #1;

    // Directed vectors, one beat at a time; also checks 2-cycle latency.
    for (int i = 0; i < 7; i++) begin
      send(vt[i].m, vt[i].din);
      @(negedge clk_i);
      check($sformatf("tbl%0d_early", i), 64'(out_valid_o), 0);
      @(negedge clk_i);
      check($sformatf("tbl%0d_valid", i), 64'(out_valid_o), 1);
      check($sformatf("tbl%0d_coded", i), coded_o, vt[i].r.coded);
      check($sformatf("tbl%0d_data", i), 64'(data_o), 64'(vt[i].r.data));
      check($sformatf("tbl%0d_flags", i), 64'({single_err_o, double_err_o, err_pos_o}),
            64'({vt[i].r.se, vt[i].r.de, vt[i].r.pos}));
      @(posedge clk_i); #1;
    end
    check("tbl_corr_cnt", 64'(corr_cnt_o), 2);
    check("tbl_uncorr_cnt", 64'(uncorr_cnt_o), 2);

    // Counter saturation and clear-versus-increment priority.
    cnt_clr_i = 1; @(posedge clk_i); #1 cnt_clr_i = 0;
    for (int i = 0; i < 5; i++) send(1, 64'h2F);
    repeat (3) @(posedge clk_i); #1;
    check("sat_corr_cnt", 64'(corr_cnt_o), 3);
    send(1, 64'h2F);
    @(posedge clk_i); #1 cnt_clr_i = 1;
    @(negedge clk_i);
    check("clr_hs_valid", 64'(out_valid_o), 1);
    @(posedge clk_i); #1 cnt_clr_i = 0;
    check("clr_wins", 64'(corr_cnt_o), 0);

    // Backpressure: 4 beats alternating encode/decode, sink stalled 5 cycles.
    for (int i = 0; i < 4; i++) begin
      logic m; logic [NW-1:0] d;
      gen_beat(m, d);
      bm[i] = (i % 2 == 1);
      if (bm[i] != m) d = ref_model(0, d).coded;
      bd[i] = d;
    end
    out_ready_i = 0; in_valid_i = 1; mode_i = bm[0]; data_i = bd[0]; acc = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_i);
      took = in_valid_i && in_ready_o;
      if (c == 4) begin
        check("bp_accepted", 64'(acc), 2);
        check("bp_in_ready", 64'(in_ready_o), 0);
      end
      if (c >= 5 && c <= 8) check($sformatf("bp_consec%0d", c - 5), 64'(out_valid_o), 1);
      if (c == 9) check("bp_drained", 64'(out_valid_o), 0);
      @(posedge clk_i); #1;
      if (took) begin
        acc++;
        if (acc < 4) begin mode_i = bm[acc]; data_i = bd[acc]; end
        else in_valid_i = 0;
      end
      if (c == 4) out_ready_i = 1;
    end
    check("bp_all_accepted", 64'(acc), 4);

    // Random traffic with random stalls and occasional counter clears.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      took = in_valid_i && in_ready_o;
      @(posedge clk_i); #1;
      if (took || !in_valid_i) begin
        if ($urandom_range(0, 3) != 0) begin
          logic m; logic [NW-1:0] d;
          gen_beat(m, d);
          in_valid_i = 1; mode_i = m; data_i = d;
        end else in_valid_i = 0;
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      cnt_clr_i   = ($urandom_range(0, 40) == 0);
    end
    in_valid_i = 0; out_ready_i = 1; cnt_clr_i = 0;
    repeat (5) @(posedge clk_i); #1;
    check("rand_drained", 64'(expq.size()), 0);

    // Reset with a full, stalled pipeline.
    send(1, 64'h2F);
    repeat (3) @(posedge clk_i); #1;
    out_ready_i = 0;
    send(0, 64'h1234);
    send(1, 64'hE);
    @(negedge clk_i);
    check("pre_rst_valid", 64'(out_valid_o), 1);
    check("pre_rst_cnt_nz", 64'(corr_cnt_o != 0), 1);
    #1 rst_i = 1;
    #1;
    check("rst_mid_valid", 64'(out_valid_o), 0);
    check("rst_mid_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 0);
    check("rst_mid_ready", 64'(in_ready_o), 1);
    repeat (2) @(posedge clk_i); #1 rst_i = 0;
    out_ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("post_rst_no_out", 64'(out_valid_o), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
